// File: rtl/pixel_window_fetch_unit_if.sv
// Pixel-request handshake, frame BRAM read port and window output of the
// pixel window fetch unit, bundled as one interface.
interface pixel_window_fetch_unit_if #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 20
);
    localparam int unsigned DIMM_BUS_WIDTH = 16;
    localparam int unsigned WIN_WIDTH      = 9 * PIX_WIDTH;

    logic                      start;
    logic [DIMM_BUS_WIDTH-1:0] frame_input_width;
    logic [DIMM_BUS_WIDTH-1:0] frame_input_height;
    logic                      req_pix;
    logic                      new_line;
    logic                      pix_ctrl_ack;
    logic                      bram_en;
    logic [ADDR_WIDTH-1:0]     bram_addr;
    logic [PIX_WIDTH-1:0]      bram_rdata;
    logic [WIN_WIDTH-1:0]      window;
    logic                      busy;
    logic                      protocol_err;

    // Environment side: control unit plus frame BRAM
    modport master (
        output start, frame_input_width, frame_input_height, req_pix, new_line, bram_rdata,
        input  pix_ctrl_ack, bram_en, bram_addr, window, busy, protocol_err
    );

    // Fetch unit side
    modport slave (
        input  start, frame_input_width, frame_input_height, req_pix, new_line, bram_rdata,
        output pix_ctrl_ack, bram_en, bram_addr, window, busy, protocol_err
    );
endinterface

// File: rtl/pixel_window_fetch_unit.sv
// Answers each pixel request by reading one 3-pixel column from the frame
// BRAM (three fixed slots, padded rows/columns read as 0), shifting it into a
// zero-padded 3x3 window and pulsing pix_ctrl_ack.
module pixel_window_fetch_unit #(
    parameter int unsigned PIX_WIDTH  = 8,
    parameter int unsigned ADDR_WIDTH = 20
) (
    input logic                       clk,
    input logic                       resetn,
    pixel_window_fetch_unit_if.slave  pw
);
    localparam int unsigned DIMM_BUS_WIDTH = 16;
    localparam int unsigned WIN_WIDTH      = 9 * PIX_WIDTH;
    localparam int unsigned ROW_WIDTH      = DIMM_BUS_WIDTH + 2;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_WAIT_REQ = 2'd1;
    localparam logic [1:0] S_FETCH    = 2'd2;
    localparam logic [1:0] S_COMMIT   = 2'd3;

    logic [1:0]                state_q, state_d;
    logic [1:0]                slot_q, slot_d;
    logic [DIMM_BUS_WIDTH-1:0] width_q, width_d;
    logic [DIMM_BUS_WIDTH-1:0] height_q, height_d;
    logic [DIMM_BUS_WIDTH-1:0] row_q, row_d;
    logic [DIMM_BUS_WIDTH-1:0] col_q, col_d;
    logic [ADDR_WIDTH-1:0]     base_q, base_d;
    logic                      line_open_q, line_open_d;
    logic                      first_col_q, first_col_d;
    logic                      rd_vld_q, rd_vld_d;
    logic                      rd_en_q, rd_en_d;
    logic                      rd_final_q, rd_final_d;
    logic [1:0]                rd_slot_q, rd_slot_d;
    logic [PIX_WIDTH-1:0]      stage0_q, stage0_d;
    logic [PIX_WIDTH-1:0]      stage1_q, stage1_d;
    logic [WIN_WIDTH-1:0]      window_q, window_d;
    logic                      ack_q, ack_d;
    logic                      bram_en_q, bram_en_d;
    logic [ADDR_WIDTH-1:0]     bram_addr_q, bram_addr_d;
    logic                      busy_q, busy_d;
    logic                      err_q, err_d;
    logic [PIX_WIDTH-1:0]      rd_pix;
    logic [ROW_WIDTH-1:0]      row_pos;

    // Next state, read pipeline, window commit and next-cycle BRAM slot
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        width_d     = width_q;
        height_d    = height_q;
        row_d       = row_q;
        col_d       = col_q;
        base_d      = base_q;
        line_open_d = line_open_q;
        first_col_d = first_col_q;
        rd_vld_d    = 1'b0;
        rd_en_d     = 1'b0;
        rd_final_d  = 1'b0;
        rd_slot_d   = slot_q;
        stage0_d    = stage0_q;
        stage1_d    = stage1_q;
        window_d    = window_q;
        ack_d       = 1'b0;
        err_d       = err_q;
        bram_en_d   = 1'b0;
        bram_addr_d = '0;
        row_pos     = '0;
        rd_pix      = rd_en_q ? pw.bram_rdata : '0;

        // Data of the slot issued last cycle; slot 2 data goes straight into the window
        if (rd_vld_q) begin
            case (rd_slot_q)
                2'd0:    stage0_d = rd_pix;
                2'd1:    stage1_d = rd_pix;
                default: begin
                    window_d = {rd_pix,   window_q[9*PIX_WIDTH-1:7*PIX_WIDTH],
                                stage1_q, window_q[6*PIX_WIDTH-1:4*PIX_WIDTH],
                                stage0_q, window_q[3*PIX_WIDTH-1:PIX_WIDTH]};
                    ack_d    = rd_final_q;
                end
            endcase
        end

        case (state_q)
            S_IDLE: begin
                if (pw.req_pix) err_d = 1'b1;
            end
            S_WAIT_REQ: begin
                if (pw.req_pix) begin
                    if (pw.new_line) begin
                        if (line_open_q) begin
                            row_d  = row_q + DIMM_BUS_WIDTH'(1);
                            base_d = base_q + ADDR_WIDTH'(width_q);
                            if ((ROW_WIDTH'(row_q) + ROW_WIDTH'(1)) >= ROW_WIDTH'(height_q)) err_d = 1'b1;
                        end else begin
                            row_d  = '0;
                            base_d = '0;
                            if (height_q == '0) err_d = 1'b1;
                        end
                        col_d       = '0;
                        line_open_d = 1'b1;
                        first_col_d = 1'b1;
                        window_d    = '0;
                        state_d     = S_FETCH;
                        slot_d      = 2'd0;
                    end else if (line_open_q) begin
                        col_d       = col_q + DIMM_BUS_WIDTH'(1);
                        first_col_d = 1'b0;
                        state_d     = S_FETCH;
                        slot_d      = 2'd0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_FETCH: begin
                if (pw.req_pix) err_d = 1'b1;
                rd_vld_d   = 1'b1;
                rd_slot_d  = slot_q;
                rd_en_d    = bram_en_q;
                rd_final_d = !first_col_q;
                if (slot_q == 2'd2) begin
                    if (first_col_q) begin
                        first_col_d = 1'b0;
                        col_d       = col_q + DIMM_BUS_WIDTH'(1);
                        slot_d      = 2'd0;
                    end else begin
                        state_d = S_COMMIT;
                    end
                end else begin
                    slot_d = slot_q + 2'd1;
                end
            end
            default: begin
                if (pw.req_pix) err_d = 1'b1;
                state_d = S_WAIT_REQ;
            end
        endcase

        busy_d = (state_d == S_FETCH) || (state_d == S_COMMIT) || (state_q == S_COMMIT);

        // start overrides everything, including a coincident request
        if (pw.start) begin
            state_d     = S_WAIT_REQ;
            slot_d      = 2'd0;
            width_d     = pw.frame_input_width;
            height_d    = pw.frame_input_height;
            line_open_d = 1'b0;
            first_col_d = 1'b0;
            rd_vld_d    = 1'b0;
            window_d    = '0;
            ack_d       = 1'b0;
            err_d       = 1'b0;
            busy_d      = 1'b0;
        end

        // Slot of the coming cycle: row index y+slot-1 lies in frame iff 1 <= y+slot <= H
        if (state_d == S_FETCH) begin
            row_pos = ROW_WIDTH'(row_d) + ROW_WIDTH'(slot_d);
            if ((row_pos != '0) && (row_pos <= ROW_WIDTH'(height_d)) && (col_d < width_d)) begin
                bram_en_d = 1'b1;
                case (slot_d)
                    2'd0:    bram_addr_d = base_d - ADDR_WIDTH'(width_d) + ADDR_WIDTH'(col_d);
                    2'd1:    bram_addr_d = base_d + ADDR_WIDTH'(col_d);
                    default: bram_addr_d = base_d + ADDR_WIDTH'(width_d) + ADDR_WIDTH'(col_d);
                endcase
            end
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            slot_q      <= 2'd0;
            width_q     <= '0;
            height_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            base_q      <= '0;
            line_open_q <= 1'b0;
            first_col_q <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_final_q  <= 1'b0;
            rd_slot_q   <= 2'd0;
            stage0_q    <= '0;
            stage1_q    <= '0;
            window_q    <= '0;
            ack_q       <= 1'b0;
            bram_en_q   <= 1'b0;
            bram_addr_q <= '0;
            busy_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            width_q     <= width_d;
            height_q    <= height_d;
            row_q       <= row_d;
            col_q       <= col_d;
            base_q      <= base_d;
            line_open_q <= line_open_d;
            first_col_q <= first_col_d;
            rd_vld_q    <= rd_vld_d;
            rd_en_q     <= rd_en_d;
            rd_final_q  <= rd_final_d;
            rd_slot_q   <= rd_slot_d;
            stage0_q    <= stage0_d;
            stage1_q    <= stage1_d;
            window_q    <= window_d;
            ack_q       <= ack_d;
            bram_en_q   <= bram_en_d;
            bram_addr_q <= bram_addr_d;
            busy_q      <= busy_d;
            err_q       <= err_d;
        end
    end

    assign pw.pix_ctrl_ack = ack_q;
    assign pw.bram_en      = bram_en_q;
    assign pw.bram_addr    = bram_addr_q;
    assign pw.window       = window_q;
    assign pw.busy         = busy_q;
    assign pw.protocol_err = err_q;
endmodule

// File: tb/tb_pixel_window_fetch_unit.sv
// Scoreboard bench for pixel_window_fetch_unit: stimulus pushes expected
// acks (window + cycle) and BRAM addresses; monitors pop and compare.
module tb_pixel_window_fetch_unit;
    localparam int unsigned PW = 8;
    localparam int unsigned AW = 20;
    localparam int unsigned WW = 9 * PW;

    typedef struct {
        logic [WW-1:0] win;
        int            cyc;
    } ack_exp_t;

    logic          clk    = 1'b0;
    logic          resetn = 1'b0;
    int            cyc    = 0;
    int            checks = 0;
    int            errors = 0;
    logic [PW-1:0] key    = '0;
    ack_exp_t      ack_q[$];
    int            addr_q[$];
    ack_exp_t      mon_e;
    int            mon_a;
    logic [WW-1:0] w0;

    pixel_window_fetch_unit_if #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW)) pw ();

    pixel_window_fetch_unit #(.PIX_WIDTH(PW), .ADDR_WIDTH(AW)) dut (
        .clk    (clk),
        .resetn (resetn),
        .pw     (pw)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Frame BRAM: pixel = address (xor key); garbage when not enabled
    always @(posedge clk) pw.bram_rdata <= pw.bram_en ? (pw.bram_addr[PW-1:0] ^ key) : 8'hA5;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [WW-1:0] win(input int v0, input int v1, input int v2,
                                          input int v3, input int v4, input int v5,
                                          input int v6, input int v7, input int v8);
        return {PW'(v8), PW'(v7), PW'(v6), PW'(v5), PW'(v4), PW'(v3), PW'(v2), PW'(v1), PW'(v0)};
    endfunction

    // Zero-padded 3x3 golden window centred on (y,x)
    function automatic logic [WW-1:0] gold(input int w, input int h, input int y, input int x);
        logic [WW-1:0] r;
        r = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                int row;
                int col;
                row = y - 1 + i;
                col = x - 1 + j;
                if (row >= 0 && row < h && col >= 0 && col < w)
                    r[(3*i+j)*PW +: PW] = PW'(row * w + col) ^ key;
            end
        end
        return r;
    endfunction

    task automatic push_col(input int w, input int h, input int y, input int k);
        for (int i = 0; i < 3; i++) begin
            int row;
            row = y - 1 + i;
            if (row >= 0 && row < h && k < w) addr_q.push_back(row * w + k);
        end
    endtask

    task automatic do_start(input int w, input int h);
        @(posedge clk); #1;
        pw.start = 1'b1;
        pw.frame_input_width  = 16'(w);
        pw.frame_input_height = 16'(h);
        @(posedge clk); #1;
        pw.start = 1'b0;
    endtask

    task automatic request(input logic nl, input int lat, input logic [WW-1:0] w, input bit want_ack);
        ack_exp_t e;
        @(posedge clk); #1;
        pw.req_pix  = 1'b1;
        pw.new_line = nl;
        if (want_ack) begin
            e.win = w;
            e.cyc = cyc + lat;
            ack_q.push_back(e);
        end
        @(posedge clk); #1;
        pw.req_pix  = 1'b0;
        pw.new_line = 1'b0;
    endtask

    task automatic drain(input string name);
        chk({name, "_acks_missing"}, 128'(ack_q.size()), 128'(0));
        chk({name, "_reads_missing"}, 128'(addr_q.size()), 128'(0));
        ack_q.delete();
        addr_q.delete();
    endtask

    // Monitor: every ack and every BRAM read must match the next expectation
    always @(negedge clk) begin
        if (resetn) begin
            if (pw.pix_ctrl_ack === 1'b1) begin
                checks++;
                if (ack_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_ack: cycle %0d window %0h, no ack expected", cyc, pw.window);
                end else begin
                    mon_e = ack_q.pop_front();
                    if (pw.window !== mon_e.win || cyc != mon_e.cyc) begin
                        errors++;
                        $display("FAIL ack_window: cycle %0d window %0h, expected cycle %0d window %0h",
                                 cyc, pw.window, mon_e.cyc, mon_e.win);
                    end
                end
            end
            if (pw.bram_en !== 1'b0) begin
                checks++;
                if (addr_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_read: cycle %0d en %b addr %0d, no read expected", cyc, pw.bram_en, pw.bram_addr);
                end else begin
                    mon_a = addr_q.pop_front();
                    if (pw.bram_en !== 1'b1 || pw.bram_addr !== AW'(mon_a)) begin
                        errors++;
                        $display("FAIL read_addr: cycle %0d addr %0d, expected %0d", cyc, pw.bram_addr, mon_a);
                    end
                end
            end
        end
    end

    initial begin
        pw.start = 1'b0;
        pw.req_pix = 1'b0;
        pw.new_line = 1'b0;
        pw.frame_input_width = '0;
        pw.frame_input_height = '0;
        w0 = win(0, 0, 0, 0, 0, 1, 0, 4, 5);

        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", 128'({pw.pix_ctrl_ack, pw.bram_en, pw.busy, pw.protocol_err, pw.bram_addr, pw.window}), 128'(0));
        resetn = 1'b1;

        // IDLE ignores requests until start
        request(1'b1, 0, '0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("idle_busy", 128'(pw.busy), 128'(0));
        drain("idle");

        // 4x3 first line and x sweep; each next request coincides with the ack
        do_start(4, 3);
        chk("start_clears_err", 128'(pw.protocol_err), 128'(0));
        addr_q.push_back(0); addr_q.push_back(4); addr_q.push_back(1); addr_q.push_back(5);
        request(1'b1, 8, w0, 1'b1);
        repeat (6) @(posedge clk);
        addr_q.push_back(2); addr_q.push_back(6);
        request(1'b0, 5, win(0, 0, 0, 0, 1, 2, 4, 5, 6), 1'b1);
        repeat (3) @(posedge clk);
        addr_q.push_back(3); addr_q.push_back(7);
        request(1'b0, 5, win(0, 0, 0, 1, 2, 3, 5, 6, 7), 1'b1);
        repeat (3) @(posedge clk);
        request(1'b0, 5, win(0, 0, 0, 2, 3, 0, 6, 7, 0), 1'b1);
        repeat (6) @(posedge clk);
        drain("line0");
        chk("line0_no_err", 128'(pw.protocol_err), 128'(0));

        // Remaining lines of the frame
        for (int y = 1; y < 3; y++) begin
            for (int x = 0; x < 4; x++) begin
                int lat;
                if (x == 0) begin
                    push_col(4, 3, y, 0);
                    push_col(4, 3, y, 1);
                    lat = 8;
                end else begin
                    push_col(4, 3, y, x + 1);
                    lat = 5;
                end
                request(x == 0, lat, gold(4, 3, y, x), 1'b1);
                repeat (lat + 1) @(posedge clk);
            end
        end
        drain("frame");
        chk("frame_no_err", 128'(pw.protocol_err), 128'(0));

        // new_line past the bottom: served, flagged
        addr_q.push_back(8); addr_q.push_back(9);
        request(1'b1, 8, win(0, 8, 9, 0, 0, 0, 0, 0, 0), 1'b1);
        repeat (9) @(posedge clk);
        drain("below_frame");
        chk("below_frame_err", 128'(pw.protocol_err), 128'(1));

        // Request without an open line
        do_start(4, 3);
        chk("restart_clears_err", 128'(pw.protocol_err), 128'(0));
        request(1'b0, 0, '0, 1'b0);
        repeat (8) @(posedge clk);
        #1;
        chk("no_line_err", 128'(pw.protocol_err), 128'(1));
        drain("no_line");

        // Request during FETCH is ignored; in-flight ack still arrives
        do_start(4, 3);
        chk("start_clears_err2", 128'(pw.protocol_err), 128'(0));
        addr_q.push_back(0); addr_q.push_back(4); addr_q.push_back(1); addr_q.push_back(5);
        request(1'b1, 8, w0, 1'b1);
        @(posedge clk); #1;
        pw.req_pix = 1'b1;
        @(posedge clk); #1;
        pw.req_pix = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("fetch_req_err", 128'(pw.protocol_err), 128'(1));
        drain("fetch_req");

        // Abort with start at n+3, then a 1x1 frame
        do_start(4, 3);
        addr_q.push_back(0); addr_q.push_back(4);
        request(1'b1, 0, '0, 1'b0);
        @(posedge clk);
        do_start(1, 1);
        repeat (10) @(posedge clk);
        drain("abort");
        key = 8'h5A;
        addr_q.push_back(0);
        request(1'b1, 8, win(0, 0, 0, 0, 8'h5A, 0, 0, 0, 0), 1'b1);
        repeat (9) @(posedge clk);
        drain("one_by_one");
        key = '0;

        // Reset mid-fetch
        do_start(4, 3);
        addr_q.push_back(0); addr_q.push_back(4); addr_q.push_back(1); addr_q.push_back(5);
        request(1'b1, 8, w0, 1'b1);
        repeat (6) @(posedge clk);
        request(1'b0, 0, '0, 1'b0);
        chk("busy_before_reset", 128'(pw.busy), 128'(1));
        @(posedge clk); #1;
        resetn = 1'b0;
        #1;
        chk("reset_mid_fetch", 128'({pw.pix_ctrl_ack, pw.bram_en, pw.busy, pw.protocol_err, pw.bram_addr, pw.window}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
        request(1'b1, 0, '0, 1'b0);
        repeat (12) @(posedge clk);
        #1;
        chk("post_reset_idle_busy", 128'(pw.busy), 128'(0));
        drain("post_reset_idle");
        do_start(4, 3);
        addr_q.push_back(0); addr_q.push_back(4); addr_q.push_back(1); addr_q.push_back(5);
        request(1'b1, 8, w0, 1'b1);
        repeat (9) @(posedge clk);
        drain("post_reset_run");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
